wb_bus_arbiter: RTL
===================

Name: wb_bus_arbiter

Overview:
- Two-master Wishbone arbiter and wait-state sequencer for the shared 16-bit system bus.
- Master 0 is the vm1 CPU; its wbm_gnt_i is driven from m0_gnt. Master 1 is a secondary bus master (serial loader / VRAM DMA).
- Grants the bus round-robin and muxes the owner onto the slave bus.
- Generates the per-transfer ack for RAM/VRAM/UART from programmable wait-state counts. Ack for self-acking slaves (CPU register file) is passed through, guarded by a bus timeout.

Parameters:
- RD_WS, 2, wait states before a read ack on counter-acked slaves (ack in cycle RD_WS+1 of stb).
- WR_WS, 0, wait states before a write ack on counter-acked slaves.
- TMO, 15, cycles to wait for s_ack_i on a self-acking slave before forcing termination.

Ports:
- mclkp  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- m0_adr, m1_adr  in  16  master addresses.
- m0_dat_o, m1_dat_o  in  16  master write data.
- m0_we, m1_we  in  1  master write enables.
- m0_sel, m1_sel  in  2  master byte selects.
- m0_cyc, m1_cyc  in  1  master cycle / bus request.
- m0_stb, m1_stb  in  1  master strobes.
- m0_gnt, m1_gnt  out  1  registered grants.
- m0_ack, m1_ack  out  1  acks to the masters.
- m0_err, m1_err  out  1  timeout error, pulsed together with the forced ack.
- m_dat_i  out  16  read data to both masters.
- s_adr  out  16  owner address to slaves.
- s_dat_o  out  16  owner write data.
- s_we  out  1  owner write enable.
- s_sel  out  2  owner byte selects.
- s_cyc, s_stb  out  1  owner cyc/stb, gated by grant.
- s_dat_i  in  16  muxed slave read data.
- s_self  in  1  addressed slave acks itself; combinational decode of s_adr.
- s_ack_i  in  1  ack from the self-acking slave.

Behaviour:
- Reset values:
  - state IDLE; m0_gnt = m1_gnt = 0; last_owner = 1, so M0 wins the first tie.
  - ws_cnt = 0; all acks and errs 0.
  - s_cyc = s_stb = 0; s_adr, s_dat_o, s_sel and s_we are driven from M0 inputs (don't-care while s_cyc = 0).
- FSM states IDLE, OWN0, OWN1; the grants are the registered state decode (m0_gnt = OWN0, m1_gnt = OWN1).
- IDLE transitions:
  - Only one cyc high: go to that master's OWN state.
  - Both cyc high: the master that is not last_owner wins.
  - Grant appears 1 cycle after cyc rises.
- OWNx transitions:
  - While mx_cyc = 1: stay; no preemption.
  - When mx_cyc = 0: if the other master's cyc = 1, go directly to its OWN state; else go to IDLE.
  - On leaving OWNx, set last_owner = x.
- Slave mux: s_* = owner's signals. s_cyc = owner cyc & gnt; s_stb = owner stb & gnt. Nothing is driven with no grant.
- ws_cnt:
  - Counts cycles while s_stb = 1 and no ack.
  - Clears on ack, on s_stb = 0, and on any ownership change.
  - Width ceil(log2(max(RD_WS, WR_WS, TMO) + 1)).
- Ack condition (combinational, ack = s_stb & ...):
  - s_self = 0 and s_we = 1: ws_cnt == WR_WS.
  - s_self = 0 and s_we = 0: ws_cnt == RD_WS.
  - s_self = 1: s_ack_i, or ws_cnt == TMO (timeout).
- Ack routing: ack goes only to the owner's mx_ack. On timeout, the owner's mx_err pulses in the same cycle.
- Ack timing:
  - With WR_WS = 0, a write is acked in the first stb cycle.
  - Ack is a single-cycle pulse per transfer. A master holding stb across transfers gets one ack every WS+1 cycles, because ws_cnt restarts from 0 after the ack.
- Read data: m_dat_i = s_dat_i, except 16'h0000 in a timeout cycle.
- Simultaneous events: if the owner drops cyc in the same cycle another master raises cyc, the handover completes in 1 cycle with no IDLE gap.
- Stale strobe: stb arriving before the grant is ignored; the counter does not run until gnt = 1.
- Reset mid-transfer: next edge forces IDLE with grants 0. ack/stb drop immediately because they are gated by gnt. No partial write is issued after reset.
- No ack is ever generated when s_cyc = 0.

Test Plan:
- Single CPU read, s_self = 0, RD_WS = 2: m0_cyc/stb rise at cycle 0 -> m0_gnt = 1 at cycle 1; m0_ack pulses at cycle 3; m_dat_i = s_dat_i (e.g. 16'o012737) in cycle 3.
- CPU write to 16'o001000 (WR_WS = 0): ack in the same cycle as the first granted stb. Three back-to-back reads with stb held -> acks 3 cycles apart.
- Contention: both cyc rise together after reset -> M0 granted. M0 drops cyc -> m1_gnt = 1 the next cycle, with no IDLE cycle between. Next tie -> M0 granted (round-robin).
- Self-acking slave (adr 16'o177700, s_self = 1), s_ack_i asserted at the 2nd stb cycle -> ack in that cycle, no err.
- Same slave with s_ack_i held 0 -> m0_ack and m0_err pulse together in cycle TMO+1 of stb (16th cycle, TMO = 15); m_dat_i = 0 in that cycle.
- RST asserted in cycle 1 of an M1 write with WR_WS = 3 -> next cycle gnt = 0, s_stb = 0, no ack issued. After RST release, M0 wins the first tie.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter and wait-state sequencer for the shared 16-bit
// system bus. Master 0 is the vm1 CPU, master 1 the serial loader / VRAM DMA.
// Ownership is round-robin without preemption; the owner is muxed onto the
// slave bus and acked either from a wait-state counter (RAM/VRAM/UART) or
// from the slave itself, with a timeout that forces termination.
module wb_bus_arbiter #(
    parameter int unsigned RD_WS = 2,
    parameter int unsigned WR_WS = 0,
    parameter int unsigned TMO   = 15
) (
    input  logic        mclkp,
    input  logic        RST,

    input  logic [15:0] m0_adr,
    input  logic [15:0] m0_dat_o,
    input  logic        m0_we,
    input  logic [1:0]  m0_sel,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic [15:0] m1_adr,
    input  logic [15:0] m1_dat_o,
    input  logic        m1_we,
    input  logic [1:0]  m1_sel,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic        m1_err,

    output logic [15:0] m_dat_i,

    output logic [15:0] s_adr,
    output logic [15:0] s_dat_o,
    output logic        s_we,
    output logic [1:0]  s_sel,
    output logic        s_cyc,
    output logic        s_stb,
    input  logic [15:0] s_dat_i,
    input  logic        s_self,
    input  logic        s_ack_i
);

    localparam int unsigned MAX_RW = (RD_WS > WR_WS) ? RD_WS : WR_WS;
    localparam int unsigned MAX_WS = (MAX_RW > TMO) ? MAX_RW : TMO;
    localparam int unsigned CW     = (MAX_WS < 1) ? 1 : $clog2(MAX_WS + 1);

    localparam logic [CW-1:0] RD_CNT  = CW'(RD_WS);
    localparam logic [CW-1:0] WR_CNT  = CW'(WR_WS);
    localparam logic [CW-1:0] TMO_CNT = CW'(TMO);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_owner;
    logic          last_owner_nxt;
    logic [CW-1:0] ws_cnt;

    logic          owner1;
    logic          own_cyc;
    logic          own_stb;
    logic          ack;
    logic          timeout;

    // Next-state: round-robin on ties from IDLE, direct handover on release.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (m0_cyc) begin
                    state_nxt = OWN0;
                end else if (m1_cyc) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc) begin
                    state_nxt      = m1_cyc ? OWN1 : IDLE;
                    last_owner_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc) begin
                    state_nxt      = m0_cyc ? OWN0 : IDLE;
                    last_owner_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge mclkp) begin
        if (RST) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Owner mux onto the slave bus; M0 is the default source when idle.
    always_comb begin
        m0_gnt  = (state == OWN0);
        m1_gnt  = (state == OWN1);
        owner1  = m1_gnt;
        s_adr   = owner1 ? m1_adr   : m0_adr;
        s_dat_o = owner1 ? m1_dat_o : m0_dat_o;
        s_we    = owner1 ? m1_we    : m0_we;
        s_sel   = owner1 ? m1_sel   : m0_sel;
        own_cyc = owner1 ? m1_cyc   : m0_cyc;
        own_stb = owner1 ? m1_stb   : m0_stb;
        s_cyc   = own_cyc & (m0_gnt | m1_gnt);
        s_stb   = own_stb & (m0_gnt | m1_gnt);
    end

    // Ack generation from the wait-state counter or the self-acking slave.
    always_comb begin
        timeout = 1'b0;
        ack     = 1'b0;
        if (s_stb) begin
            if (s_self) begin
                timeout = !s_ack_i && (ws_cnt == TMO_CNT);
                ack     = s_ack_i || (ws_cnt == TMO_CNT);
            end else if (s_we) begin
                ack = (ws_cnt == WR_CNT);
            end else begin
                ack = (ws_cnt == RD_CNT);
            end
        end
        m0_ack  = ack & m0_gnt;
        m1_ack  = ack & m1_gnt;
        m0_err  = timeout & m0_gnt;
        m1_err  = timeout & m1_gnt;
        m_dat_i = timeout ? '0 : s_dat_i;
    end

    // Wait-state counter: runs while a granted strobe is pending; saturating
    // so a mid-transfer change of s_we/s_self can never wrap it.
    always_ff @(posedge mclkp) begin
        if (RST) begin
            ws_cnt <= '0;
        end else if (ack || !s_stb || (state_nxt != state)) begin
            ws_cnt <= '0;
        end else if (ws_cnt != MAX_CNT) begin
            ws_cnt <= ws_cnt + 1'b1;
        end
    end

endmodule
